// File: rtl/hack_cpu.sv
// hack_cpu: single-cycle Hack CPU core.
// Decodes one instruction per clock, drives the data-memory interface
// combinationally and updates the A, D and PC registers on the rising edge.
// The ALU always works on the pre-edge A and D values, and addressM and the
// jump target also use the pre-edge A.

module hack_cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] inM,
  input  logic [15:0] instruction,
  output logic [15:0] outM,
  output logic [14:0] addressM,
  output logic [14:0] PC,
  output logic        writeM,
  output logic [6:0]  control_word
);

  // Architectural registers
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [14:0] pc_q, pc_d;

  // Decoded instruction fields
  logic        is_c;
  logic        sel_m;
  logic        zx, nx, zy, ny, f_add, no;
  logic        dest_a, dest_d, dest_m;
  logic        jmp_lt, jmp_eq, jmp_gt;

  // ALU datapath
  logic [15:0] alu_y_src;
  logic [15:0] alu_x, alu_y;
  logic [15:0] alu_raw;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic        jump_taken;

  // Bits [14:13] of a C-instruction carry no meaning in this architecture
  logic        unused_c_bits;
  assign unused_c_bits = ^instruction[14:13];

  // Split the instruction into its fields; destinations and jumps only
  // exist for C-instructions, so they are masked off for A-instructions
  always_comb begin
    is_c   = instruction[15];
    sel_m  = instruction[12];
    zx     = instruction[11];
    nx     = instruction[10];
    zy     = instruction[9];
    ny     = instruction[8];
    f_add  = instruction[7];
    no     = instruction[6];
    dest_a = is_c & instruction[5];
    dest_d = is_c & instruction[4];
    dest_m = is_c & instruction[3];
    jmp_lt = is_c & instruction[2];
    jmp_eq = is_c & instruction[1];
    jmp_gt = is_c & instruction[0];
  end

  // ALU: x comes from D, y from A or M, each optionally zeroed then inverted
  always_comb begin
    alu_y_src = sel_m ? inM : a_q;
    alu_x     = zx ? 16'h0000 : d_q;
    if (nx) alu_x = ~alu_x;
    alu_y     = zy ? 16'h0000 : alu_y_src;
    if (ny) alu_y = ~alu_y;
    alu_raw   = f_add ? (alu_x + alu_y) : (alu_x & alu_y);
    alu_out   = no ? ~alu_raw : alu_raw;
    alu_zr    = (alu_out == 16'h0000);
    alu_ng    = alu_out[15];
  end

  // Jump condition from the ALU status flags
  always_comb begin
    jump_taken = (jmp_lt & alu_ng) |
                 (jmp_eq & alu_zr) |
                 (jmp_gt & ~alu_ng & ~alu_zr);
  end

  // Next-state values for A, D and PC; the jump target is the pre-edge A
  always_comb begin
    a_d  = a_q;
    d_d  = d_q;
    pc_d = pc_q + 15'd1;
    if (!is_c) begin
      a_d = instruction;
    end else begin
      if (dest_a) a_d = alu_out;
      if (dest_d) d_d = alu_out;
      if (jump_taken) pc_d = a_q[14:0];
    end
  end

  // Register update with synchronous reset clearing all state
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= 16'h0000;
      d_q  <= 16'h0000;
      pc_q <= 15'd0;
    end else begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

  // Memory interface and observation outputs; writes are suppressed in reset
  always_comb begin
    outM         = alu_out;
    addressM     = a_q[14:0];
    PC           = pc_q;
    writeM       = dest_m & ~reset;
    control_word = is_c ? instruction[12:6] : 7'd0;
  end

endmodule

// File: tb/tb_hack_cpu.sv
// tb_hack_cpu: table-driven directed test for hack_cpu.

module tb_hack_cpu;

  logic        clk;
  logic        reset;
  logic [15:0] inM;
  logic [15:0] instruction;
  logic [15:0] outM;
  logic [14:0] addressM;
  logic [14:0] PC;
  logic        writeM;
  logic [6:0]  control_word;

  int compared;
  int mismatched;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] inm;
    bit          chk_out;
    logic [15:0] exp_out;
    logic        exp_wr;
    logic [14:0] exp_addr;
    logic [6:0]  exp_cw;
    logic [14:0] exp_pc;
    logic [14:0] exp_addr_after;
  } vec_t;

  vec_t vecs[$];

  hack_cpu dut (
    .clk          (clk),
    .reset        (reset),
    .inM          (inM),
    .instruction  (instruction),
    .outM         (outM),
    .addressM     (addressM),
    .PC           (PC),
    .writeM       (writeM),
    .control_word (control_word)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive the instruction and RAM read data, then let the logic settle
  task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] inm);
    instruction = instr;
    inM         = inm;
    #1;
  endtask

  // Compare one observed value against the expected one
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  // Advance past the next rising edge and sample away from it
  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Directed vectors; state carries over from one to the next
    //             instr     inM      chk  out      wr    addr   cw     pc     addr_after
    vecs.push_back('{16'h013D, 16'd0,    1'b0, 16'd0,    1'b0, 15'd0,   7'h00, 15'd3,   15'd317});  // @317
    vecs.push_back('{16'hEC10, 16'd0,    1'b1, 16'd317,  1'b0, 15'd317, 7'h30, 15'd4,   15'd317});  // D=A
    vecs.push_back('{16'h0025, 16'd0,    1'b0, 16'd0,    1'b0, 15'd317, 7'h00, 15'd5,   15'd37});   // @37
    vecs.push_back('{16'hEC10, 16'd0,    1'b1, 16'd37,   1'b0, 15'd37,  7'h30, 15'd6,   15'd37});   // D=A
    vecs.push_back('{16'h0136, 16'd0,    1'b0, 16'd0,    1'b0, 15'd37,  7'h00, 15'd7,   15'd310});  // @310
    vecs.push_back('{16'hF088, 16'd1234, 1'b1, 16'd1271, 1'b1, 15'd310, 7'h42, 15'd8,   15'd310});  // M=D+M
    vecs.push_back('{16'hFCA8, 16'd1271, 1'b1, 16'd1270, 1'b1, 15'd310, 7'h72, 15'd9,   15'd1270}); // AM=M-1
    vecs.push_back('{16'h0005, 16'd0,    1'b0, 16'd0,    1'b0, 15'd1270,7'h00, 15'd10,  15'd5});    // @5
    vecs.push_back('{16'hECD0, 16'd0,    1'b1, 16'hFFFB, 1'b0, 15'd5,   7'h33, 15'd11,  15'd5});    // D=-A
    vecs.push_back('{16'h0064, 16'd0,    1'b0, 16'd0,    1'b0, 15'd5,   7'h00, 15'd12,  15'd100});  // @100
    vecs.push_back('{16'hE304, 16'd0,    1'b1, 16'hFFFB, 1'b0, 15'd100, 7'h0C, 15'd100, 15'd100});  // D;JLT
    vecs.push_back('{16'hE301, 16'd0,    1'b1, 16'hFFFB, 1'b0, 15'd100, 7'h0C, 15'd101, 15'd100});  // D;JGT
    vecs.push_back('{16'hEA87, 16'd0,    1'b1, 16'd0,    1'b0, 15'd100, 7'h2A, 15'd100, 15'd100});  // 0;JMP
    vecs.push_back('{16'hEA90, 16'd0,    1'b1, 16'd0,    1'b0, 15'd100, 7'h2A, 15'd101, 15'd100});  // D=0
    vecs.push_back('{16'hE302, 16'd0,    1'b1, 16'd0,    1'b0, 15'd100, 7'h0C, 15'd100, 15'd100});  // D;JEQ
    vecs.push_back('{16'h0007, 16'd0,    1'b0, 16'd0,    1'b0, 15'd100, 7'h00, 15'd101, 15'd7});    // @7
    vecs.push_back('{16'hEC10, 16'd0,    1'b1, 16'd7,    1'b0, 15'd7,   7'h30, 15'd102, 15'd7});    // D=A
    vecs.push_back('{16'h0009, 16'd0,    1'b0, 16'd0,    1'b0, 15'd7,   7'h00, 15'd103, 15'd9});    // @9
    vecs.push_back('{16'hEA88, 16'd0,    1'b1, 16'd0,    1'b1, 15'd9,   7'h2A, 15'd104, 15'd9});    // M=0
    vecs.push_back('{16'hEE88, 16'd0,    1'b1, 16'hFFFF, 1'b1, 15'd9,   7'h3A, 15'd105, 15'd9});    // M=-1
    vecs.push_back('{16'hE008, 16'd0,    1'b1, 16'd1,    1'b1, 15'd9,   7'h00, 15'd106, 15'd9});    // M=D&A
    vecs.push_back('{16'hE548, 16'd0,    1'b1, 16'd15,   1'b1, 15'd9,   7'h15, 15'd107, 15'd9});    // M=D|A
    vecs.push_back('{16'hE1C8, 16'd0,    1'b1, 16'd2,    1'b1, 15'd9,   7'h07, 15'd108, 15'd9});    // M=A-D
    vecs.push_back('{16'hE7F7, 16'd0,    1'b1, 16'd8,    1'b0, 15'd9,   7'h1F, 15'd9,   15'd8});    // AD=D+1;JMP
    vecs.push_back('{16'hE310, 16'd0,    1'b1, 16'd8,    1'b0, 15'd8,   7'h0C, 15'd10,  15'd8});    // D=D

    // Reset held for two edges
    reset = 1'b1;
    applyStimulus(16'hEC10, 16'd0);
    stepEdge();
    stepEdge();
    checkOutput("reset_pc",   16'(PC),       16'd0);
    checkOutput("reset_addr", 16'(addressM), 16'd0);
    checkOutput("reset_wr",   16'(writeM),   16'd0);
    applyStimulus(16'hE308, 16'd0);
    checkOutput("reset_wr_forced", 16'(writeM), 16'd0);
    applyStimulus(16'hEC10, 16'd0);

    // First edges after release count up from 0
    #2;
    reset = 1'b0;
    #1;
    checkOutput("release_pc0", 16'(PC), 16'd0);
    stepEdge();
    checkOutput("release_pc1", 16'(PC), 16'd1);
    stepEdge();
    checkOutput("release_pc2", 16'(PC), 16'd2);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].instr, vecs[i].inm);
      if (vecs[i].chk_out)
        checkOutput($sformatf("v%0d_outM", i), outM, vecs[i].exp_out);
      checkOutput($sformatf("v%0d_writeM", i), 16'(writeM), 16'(vecs[i].exp_wr));
      checkOutput($sformatf("v%0d_addressM", i), 16'(addressM), 16'(vecs[i].exp_addr));
      checkOutput($sformatf("v%0d_cw", i), 16'(control_word), 16'(vecs[i].exp_cw));
      stepEdge();
      checkOutput($sformatf("v%0d_pc", i), 16'(PC), 16'(vecs[i].exp_pc));
      checkOutput($sformatf("v%0d_addr_after", i), 16'(addressM), 16'(vecs[i].exp_addr_after));
    end

    // PC wrap: jump to 32767, then a non-jump instruction wraps to 0
    applyStimulus(16'h7FFF, 16'd0);
    stepEdge();
    applyStimulus(16'hEA87, 16'd0);
    stepEdge();
    checkOutput("wrap_pc_max", 16'(PC), 16'd32767);
    applyStimulus(16'hE310, 16'd0);
    stepEdge();
    checkOutput("wrap_pc_zero", 16'(PC), 16'd0);

    // Reset mid-run: write suppressed, state cleared on the edge
    reset = 1'b1;
    applyStimulus(16'hE308, 16'd0);
    checkOutput("midreset_wr",   16'(writeM), 16'd0);
    checkOutput("midreset_outM", outM,        16'd8);
    stepEdge();
    checkOutput("midreset_pc",   16'(PC),       16'd0);
    checkOutput("midreset_addr", 16'(addressM), 16'd0);
    checkOutput("midreset_D",    outM,          16'd0);
    reset = 1'b0;
    #1;
    checkOutput("postreset_wr", 16'(writeM), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
